uart_rx_async: RTL and testbench

- Asynchronous UART receiver. It is the receive-side counterpart of the UART transmitter in the same core.
- It oversamples the serial input rx at 16x the bit rate, using a one-clk-wide baud_pulse strobe.
- It deframes start, 7 or 8 data bits (LSB first), optional parity, and one stop bit.
- Each received byte is presented either on a holding register with an rxrdy flag (RX_FIFO=0) or as a one-cycle write strobe into an external RX FIFO (RX_FIFO=1).

---
 rtl/uart_rx_async_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx_async.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_async.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_async_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and the
// oversample counts that place each sample in the middle of a bit cell.
package uart_rx_async_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Half a bit after the start edge, then a full bit between samples.
  localparam logic [3:0] SAMP_MID = 4'd7;
  localparam logic [3:0] SAMP_END = 4'd15;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous level; resets to 1 so an
// idle-high serial line reads as idle straight out of reset.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset
//   d       : asynchronous input
//   q       : synchronized output
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_async.sv
// UART receiver, 16x oversampled by baud_pulse. Deframes start, 7/8 data
// bits LSB first, optional parity and one stop bit, then delivers the byte
// to a holding register (RX_FIFO=0) or as a write strobe (RX_FIFO=1).
//   clk, reset_n      : clock, asynchronous active-low reset
//   baud_pulse        : 16x bit-rate sampling enable
//   rx                : asynchronous serial input, idles high
//   bit8, parity_en,
//   odd_n_even        : frame format, sampled live
//   read_rx_byte      : host consumed rx_byte (RX_FIFO=0)
//   clear_status      : clears overflow
//   fifo_full         : external FIFO full (RX_FIFO=1)
//   rx_byte, rxrdy    : received byte and unread flag
//   fifo_write_rx     : active-low one-clk FIFO write strobe
//   parity_err, framing_err, overflow : status
module uart_rx_async #(
  parameter int unsigned RX_FIFO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       clear_status,
  input  logic       fifo_full,
  output logic [7:0] rx_byte,
  output logic       rxrdy,
  output logic       fifo_write_rx,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  import uart_rx_async_pkg::*;

  logic       rx_s;
  rx_state_e  state;
  logic [3:0] samp_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       par_bit;
  logic       stop_bit;
  logic       complete;
  // Cleared after a stop bit sampled low so a held-low line (break) is not
  // mistaken for a new start edge.
  logic       armed;
  logic       wr_pend;

  logic [2:0] last_bit;
  logic [7:0] new_byte;
  logic       exp_par;
  logic       new_perr;
  logic       ovf_set;

  uart_rx_sync u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_comb begin
    last_bit = bit8 ? 3'd7 : 3'd6;
    new_byte = {bit8 & shift[7], shift[6:0]};
    exp_par  = odd_n_even ^ (^new_byte);
    new_perr = parity_en & (par_bit != exp_par);
    ovf_set  = 1'b0;
    if (complete) begin
      if (RX_FIFO == 0) ovf_set = rxrdy & ~read_rx_byte;
      else              ovf_set = fifo_full;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RX_IDLE;
      samp_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      par_bit  <= 1'b0;
      stop_bit <= 1'b1;
      complete <= 1'b0;
      armed    <= 1'b1;
    end else begin
      complete <= 1'b0;
      if (baud_pulse) begin
        samp_cnt <= samp_cnt + 4'd1;
        unique case (state)
          RX_IDLE: begin
            samp_cnt <= 4'd0;
            if (!armed) armed <= rx_s;
            else if (!rx_s) state <= RX_START;
          end
          RX_START: begin
            if (samp_cnt == SAMP_MID) begin
              samp_cnt <= 4'd0;
              bit_cnt  <= 3'd0;
              state    <= rx_s ? RX_IDLE : RX_DATA;
            end
          end
          RX_DATA: begin
            if (samp_cnt == SAMP_END) begin
              shift[bit_cnt] <= rx_s;
              if (bit_cnt == last_bit) state <= parity_en ? RX_PARITY : RX_STOP;
              else bit_cnt <= bit_cnt + 3'd1;
            end
          end
          RX_PARITY: begin
            if (samp_cnt == SAMP_END) begin
              par_bit <= rx_s;
              state   <= RX_STOP;
            end
          end
          RX_STOP: begin
            if (samp_cnt == SAMP_END) begin
              stop_bit <= rx_s;
              armed    <= rx_s;
              complete <= 1'b1;
              state    <= RX_IDLE;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_byte       <= 8'd0;
      rxrdy         <= 1'b0;
      fifo_write_rx <= 1'b1;
      parity_err    <= 1'b0;
      framing_err   <= 1'b0;
      overflow      <= 1'b0;
      wr_pend       <= 1'b0;
    end else begin
      // Strobe trails the rx_byte load by one clk so the byte is stable.
      fifo_write_rx <= ~wr_pend;
      wr_pend       <= 1'b0;
      overflow      <= (overflow & ~clear_status) | ovf_set;
      if (complete) begin
        parity_err  <= new_perr;
        framing_err <= ~stop_bit;
        if (RX_FIFO == 0) begin
          if (!rxrdy || read_rx_byte) begin
            rx_byte <= new_byte;
            rxrdy   <= 1'b1;
          end
        end else if (!fifo_full) begin
          rx_byte <= new_byte;
          wr_pend <= 1'b1;
        end
      end else if (RX_FIFO == 0 && read_rx_byte) begin
        rxrdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_async.sv
module tb_uart_rx_async;

  logic clk = 1'b0;
  logic reset_n, baud_pulse, rx, bit8, parity_en, odd_n_even;
  logic read_rx_byte, clear_status, fifo_full;
  logic [7:0] rx_byte0, rx_byte1;
  logic rxrdy0, rxrdy1, wr0, wr1, perr0, perr1, ferr0, ferr1, ovf0, ovf1;

  always #5 clk = ~clk;

  uart_rx_async #(.RX_FIFO(0)) u_dut_hold (
    .clk(clk), .reset_n(reset_n), .baud_pulse(baud_pulse), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .clear_status(clear_status), .fifo_full(fifo_full), .rx_byte(rx_byte0), .rxrdy(rxrdy0),
    .fifo_write_rx(wr0), .parity_err(perr0), .framing_err(ferr0), .overflow(ovf0)
  );

  uart_rx_async #(.RX_FIFO(1)) u_dut_fifo (
    .clk(clk), .reset_n(reset_n), .baud_pulse(baud_pulse), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .clear_status(clear_status), .fifo_full(fifo_full), .rx_byte(rx_byte1), .rxrdy(rxrdy1),
    .fifo_write_rx(wr1), .parity_err(perr1), .framing_err(ferr1), .overflow(ovf1)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: what each output must show, updated per frame outcome.
  logic [7:0] exp0_byte, exp1_byte;
  bit exp0_rxrdy, exp0_ovf, exp1_ovf, exp_perr, exp_ferr, exp1_wr_n, wr_pend;
  bit cmp_en = 1'b0;
  int n_strobes;
  logic [7:0] strobe_bytes[$];

  // Baud generator state, advanced only by step().
  int baud_div = 4;
  int baud_cnt = 0;
  bit pulsed = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("hold.rx_byte", {24'd0, rx_byte0}, {24'd0, exp0_byte});
      check("hold.rxrdy", {31'd0, rxrdy0}, {31'd0, exp0_rxrdy});
      check("hold.fifo_write_rx", {31'd0, wr0}, 32'd1);
      check("hold.parity_err", {31'd0, perr0}, {31'd0, exp_perr});
      check("hold.framing_err", {31'd0, ferr0}, {31'd0, exp_ferr});
      check("hold.overflow", {31'd0, ovf0}, {31'd0, exp0_ovf});
      check("fifo.rx_byte", {24'd0, rx_byte1}, {24'd0, exp1_byte});
      check("fifo.rxrdy", {31'd0, rxrdy1}, 32'd0);
      check("fifo.fifo_write_rx", {31'd0, wr1}, {31'd0, exp1_wr_n});
      check("fifo.parity_err", {31'd0, perr1}, {31'd0, exp_perr});
      check("fifo.framing_err", {31'd0, ferr1}, {31'd0, exp_ferr});
      check("fifo.overflow", {31'd0, ovf1}, {31'd0, exp1_ovf});
      if (wr1 === 1'b0) begin
        n_strobes++;
        strobe_bytes.push_back(rx_byte1);
      end
    end
  end

  task automatic model_reset();
    exp0_byte = 8'd0; exp1_byte = 8'd0; exp0_rxrdy = 0; exp0_ovf = 0; exp1_ovf = 0;
    exp_perr = 0; exp_ferr = 0; exp1_wr_n = 1; wr_pend = 0;
  endtask

  // One clk: inputs change 1 time unit after the edge; the fifo strobe is
  // expected in the clk following a write.
  task automatic step();
    @(posedge clk);
    #1;
    pulsed = baud_pulse;
    exp1_wr_n = !wr_pend;
    wr_pend = 0;
    if (baud_cnt == 0) begin
      baud_pulse = 1'b1;
      baud_cnt = baud_div - 1;
    end else begin
      baud_pulse = 1'b0;
      baud_cnt--;
    end
  endtask

  task automatic wait_pulse();
    for (int i = 0; i < 16; i++) begin
      step();
      if (pulsed) return;
    end
    check("baud.timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_pulses(input int n, input logic v);
    rx = v;
    repeat (n) wait_pulse();
  endtask

  task automatic model_complete(input logic [7:0] dm, input bit perr, input bit ferr,
                                input bit rd, input bit full, input bit clr);
    exp_perr = perr;
    exp_ferr = ferr;
    if (clr) begin
      exp0_ovf = 0;
      exp1_ovf = 0;
    end
    if (rd || !exp0_rxrdy) begin
      exp0_byte = dm;
      exp0_rxrdy = 1;
    end else begin
      exp0_ovf = 1;
    end
    if (!full) begin
      exp1_byte = dm;
      wr_pend = 1;
    end else begin
      exp1_ovf = 1;
    end
  endtask

  // Sends one frame, 16 pulses per bit. The stop bit is sampled at its 9th
  // pulse; the frame completes on the following clk, where rd/clr land.
  task automatic send_frame(input logic [7:0] d, input bit b8, input bit pen, input bit odd,
                            input bit flip, input bit stop_v, input bit rd, input bit full,
                            input bit clr);
    bit bits[$];
    logic [7:0] dm;
    bit par_sent;
    bit perr;
    int nb;
    if (!pulsed) wait_pulse();
    bit8 = b8; parity_en = pen; odd_n_even = odd; fifo_full = full;
    dm = b8 ? d : {1'b0, d[6:0]};
    bits.push_back(1'b0);
    for (int i = 0; i < (b8 ? 8 : 7); i++) bits.push_back(d[i]);
    par_sent = odd ^ (^dm) ^ flip;
    if (pen) bits.push_back(par_sent);
    bits.push_back(stop_v);
    perr = pen && (par_sent != (odd ^ (^dm)));
    nb = bits.size();
    for (int j = 0; j < nb; j++) begin
      rx = bits[j];
      for (int k = 1; k <= 16; k++) begin
        wait_pulse();
        if (j == nb - 1 && k == 9) begin
          read_rx_byte = rd;
          clear_status = clr;
          step();
          read_rx_byte = 0;
          clear_status = 0;
          model_complete(dm, perr, !stop_v, rd, full, clr);
        end
      end
    end
  endtask

  task automatic read_byte();
    read_rx_byte = 1;
    step();
    read_rx_byte = 0;
    exp0_rxrdy = 0;
  endtask

  task automatic clear_ovf();
    clear_status = 1;
    step();
    clear_status = 0;
    exp0_ovf = 0;
    exp1_ovf = 0;
  endtask

  initial begin
    reset_n = 0; baud_pulse = 0; rx = 1; bit8 = 1; parity_en = 0; odd_n_even = 0;
    read_rx_byte = 0; clear_status = 0; fifo_full = 0;
    model_reset();
    n_strobes = 0;
    repeat (3) step();
    cmp_en = 1;
    check("reset.rx_byte", {24'd0, rx_byte0}, 32'h00);
    check("reset.rxrdy", {31'd0, rxrdy0}, 32'd0);
    check("reset.fifo_write_rx", {31'd0, wr1}, 32'd1);
    check("reset.overflow", {31'd0, ovf0}, 32'd0);
    reset_n = 1;
    idle_pulses(4, 1'b1);

    // 8N1 byte, then host read
    send_frame(8'hA5, 1, 0, 0, 0, 1, 0, 0, 0);
    check("a5.rx_byte", {24'd0, rx_byte0}, 32'hA5);
    check("a5.rxrdy", {31'd0, rxrdy0}, 32'd1);
    check("a5.parity_err", {31'd0, perr0}, 32'd0);
    check("a5.framing_err", {31'd0, ferr0}, 32'd0);
    read_byte();
    check("a5.read_rxrdy", {31'd0, rxrdy0}, 32'd0);

    // 7O1, good then bad parity
    send_frame(8'h35, 0, 1, 1, 0, 1, 0, 0, 0);
    check("35.rx_byte", {24'd0, rx_byte0}, 32'h35);
    check("35.parity_ok", {31'd0, perr0}, 32'd0);
    read_byte();
    send_frame(8'h35, 0, 1, 1, 1, 1, 0, 0, 0);
    check("35.parity_bad", {31'd0, perr0}, 32'd1);
    read_byte();

    // Short low glitch: false start, nothing changes
    idle_pulses(4, 1'b0);
    idle_pulses(12, 1'b1);
    check("glitch.rxrdy", {31'd0, rxrdy0}, 32'd0);
    check("glitch.parity_err", {31'd0, perr0}, 32'd1);

    // Stop bit driven low
    send_frame(8'h3C, 1, 0, 0, 0, 0, 0, 0, 0);
    check("3c.rx_byte", {24'd0, rx_byte0}, 32'h3C);
    check("3c.framing_err", {31'd0, ferr0}, 32'd1);
    idle_pulses(2, 1'b1);
    read_byte();

    // Overflow with no read, then clear
    send_frame(8'h11, 1, 0, 0, 0, 1, 0, 0, 0);
    send_frame(8'h22, 1, 0, 0, 0, 1, 0, 0, 0);
    check("ovf.rx_byte", {24'd0, rx_byte0}, 32'h11);
    check("ovf.overflow", {31'd0, ovf0}, 32'd1);
    clear_ovf();
    check("ovf.cleared", {31'd0, ovf0}, 32'd0);
    read_byte();
    // Read on the completion clk of the second frame
    send_frame(8'h11, 1, 0, 0, 0, 1, 0, 0, 0);
    send_frame(8'h22, 1, 0, 0, 0, 1, 1, 0, 0);
    check("rdcpl.rx_byte", {24'd0, rx_byte0}, 32'h22);
    check("rdcpl.overflow", {31'd0, ovf0}, 32'd0);
    check("rdcpl.rxrdy", {31'd0, rxrdy0}, 32'd1);
    read_byte();
    clear_ovf();

    // FIFO mode: three back-to-back frames, FIFO full on the third
    n_strobes = 0;
    strobe_bytes.delete();
    send_frame(8'h01, 1, 0, 0, 0, 1, 0, 0, 0);
    send_frame(8'h02, 1, 0, 0, 0, 1, 0, 0, 0);
    send_frame(8'h03, 1, 0, 0, 0, 1, 0, 1, 0);
    idle_pulses(4, 1'b1);
    fifo_full = 0;
    check("fifo.strobes", n_strobes, 32'd2);
    if (strobe_bytes.size() == 2) begin
      check("fifo.byte0", {24'd0, strobe_bytes[0]}, 32'h01);
      check("fifo.byte1", {24'd0, strobe_bytes[1]}, 32'h02);
    end else begin
      check("fifo.strobe_bytes", strobe_bytes.size(), 32'd2);
    end
    check("fifo.overflow", {31'd0, ovf1}, 32'd1);
    read_byte();
    clear_ovf();

    // Break: line held low well past the frame
    send_frame(8'h00, 1, 0, 0, 0, 0, 0, 0, 0);
    idle_pulses(60, 1'b0);
    check("break.rx_byte", {24'd0, rx_byte0}, 32'h00);
    check("break.framing_err", {31'd0, ferr0}, 32'd1);
    idle_pulses(2, 1'b1);
    read_byte();

    // Reset mid-data, then a clean frame
    wait_pulse();
    rx = 0;
    repeat (16) wait_pulse();
    for (int i = 0; i < 3; i++) begin
      rx = (i == 0) ? 1'b0 : 1'b1;  // first bits of 0x7E: 0,1,1
      repeat (16) wait_pulse();
    end
    repeat (8) wait_pulse();
    reset_n = 0;
    rx = 1;
    model_reset();
    repeat (3) step();
    check("rst.rx_byte", {24'd0, rx_byte0}, 32'h00);
    check("rst.fifo_write_rx", {31'd0, wr1}, 32'd1);
    check("rst.framing_err", {31'd0, ferr0}, 32'd0);
    reset_n = 1;
    idle_pulses(4, 1'b1);
    send_frame(8'h81, 1, 0, 0, 0, 1, 0, 0, 0);
    check("81.rx_byte", {24'd0, rx_byte0}, 32'h81);
    check("81.fifo_rx_byte", {24'd0, rx_byte1}, 32'h81);
    read_byte();

    // Randomized frames against the model
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      bit stop_v;
      d = 8'($urandom);
      stop_v = ($urandom_range(0, 7) != 0);
      baud_div = $urandom_range(3, 6);
      send_frame(d, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), stop_v,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0));
      if (!stop_v) idle_pulses(2, 1'b1);
      if ($urandom_range(0, 1) == 1) read_byte();
      if ($urandom_range(0, 4) == 0) clear_ovf();
      if ($urandom_range(0, 2) == 0) idle_pulses($urandom_range(1, 20), 1'b1);
    end
    idle_pulses(4, 1'b1);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
